// File: rtl/matmul_ctrl_seq.sv
// matmul_ctrl_seq: decodes the matmul control register and sequences one
// multiply: accumulator clear, operand fetch (A then B), PE compute for the
// wavefront length, result drain, then a done pulse back to the register.
module matmul_ctrl_seq #(
    parameter int DIM_W = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      control_register_i,
    output logic             op_req_o,
    output logic             op_sel_o,
    output logic [DIM_W-1:0] op_row_o,
    output logic [DIM_W-1:0] op_col_o,
    input  logic             op_gnt_i,
    output logic             pe_clear_o,
    output logic             pe_en_o,
    output logic             res_valid_o,
    output logic [DIM_W-1:0] res_row_o,
    output logic [DIM_W-1:0] res_col_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        LOAD_A    = 3'd2,
        LOAD_B    = 3'd3,
        COMPUTE   = 3'd4,
        WRITEBACK = 3'd5,
        DONE      = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
    logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rla_q, rla_d, rlb_q, rlb_d;
    // The dataflow field's only consumer here is the reserved-code check, so
    // the latched dataflow reduces to the sticky error bit.
    logic             err_q, err_d;
    // One-cycle done pulse for a rejected (reserved dataflow) start; also
    // blocks re-acceptance while the register still shows the start bit.
    logic             edone_q, edone_d;

    logic             accept;
    logic             adv;
    logic [DIM_W-1:0] last_row, last_col;
    logic [CNT_W-1:0] cmp_last;

    assign accept   = (state_q == IDLE) && !edone_q &&
                      control_register_i[0] && !control_register_i[1];
    // Compute runs (n+1)+(k+1)+(m+1)-2 cycles; the counter's last value is n+k+m.
    assign cmp_last = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q);

    // State, scan indices, compute counter and latched fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            rla_q   <= 1'b0;
            rlb_q   <= 1'b0;
            err_q   <= 1'b0;
            edone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            k_q     <= k_d;
            m_q     <= m_d;
            rla_q   <= rla_d;
            rlb_q   <= rlb_d;
            err_q   <= err_d;
            edone_q <= edone_d;
        end
    end

    // Next-state logic and state-decoded outputs; outputs are zero outside
    // the state that owns them.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        k_d         = k_q;
        m_d         = m_q;
        rla_d       = rla_q;
        rlb_d       = rlb_q;
        err_d       = err_q;
        edone_d     = 1'b0;
        op_req_o    = 1'b0;
        op_sel_o    = 1'b0;
        op_row_o    = '0;
        op_col_o    = '0;
        pe_clear_o  = 1'b0;
        pe_en_o     = 1'b0;
        res_valid_o = 1'b0;
        res_row_o   = '0;
        res_col_o   = '0;
        done_o      = 1'b0;
        adv         = 1'b0;
        last_row    = n_q;
        last_col    = k_q;

        case (state_q)
            IDLE: begin
                done_o = edone_q;
                if (accept) begin
                    n_d   = control_register_i[9:8];
                    k_d   = control_register_i[11:10];
                    m_d   = control_register_i[13:12];
                    rla_d = control_register_i[14];
                    rlb_d = control_register_i[15];
                    row_d = '0;
                    col_d = '0;
                    cnt_d = '0;
                    if (control_register_i[7:6] == 2'd3) begin
                        err_d   = 1'b1;
                        edone_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                pe_clear_o = 1'b1;
                row_d      = '0;
                col_d      = '0;
                if (rla_q)      state_d = LOAD_A;
                else if (rlb_q) state_d = LOAD_B;
                else            state_d = COMPUTE;
            end
            LOAD_A: begin
                op_req_o = 1'b1;
                op_row_o = row_q;
                op_col_o = col_q;
                adv      = op_gnt_i;
                last_row = n_q;
                last_col = k_q;
            end
            LOAD_B: begin
                op_req_o = 1'b1;
                op_sel_o = 1'b1;
                op_row_o = row_q;
                op_col_o = col_q;
                adv      = op_gnt_i;
                last_row = k_q;
                last_col = m_q;
            end
            COMPUTE: begin
                pe_en_o = 1'b1;
                if (cnt_q == cmp_last) begin
                    cnt_d   = '0;
                    state_d = WRITEBACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITEBACK: begin
                res_valid_o = 1'b1;
                res_row_o   = row_q;
                res_col_o   = col_q;
                adv         = res_ready_i;
                last_row    = n_q;
                last_col    = m_q;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shared row-major scan for both operand loads and the result drain.
        if (adv) begin
            if (col_q == last_col) begin
                col_d = '0;
                if (row_q == last_row) begin
                    row_d = '0;
                    case (state_q)
                        LOAD_A:  state_d = rlb_q ? LOAD_B : COMPUTE;
                        LOAD_B:  state_d = COMPUTE;
                        default: state_d = DONE;
                    endcase
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign error_o = err_q;
    assign state_o = state_q;

endmodule

// File: doc/matmul_ctrl_seq.md
Name: matmul_ctrl_seq

Overview:
- Consumer side of the 16-bit control register: decodes the start, mode, dataflow, dimension and reload fields and sequences one matrix multiply.
- Fetches operands A and B through a request/grant port, runs the PE array for the wavefront cycle count, drains results through a valid/ready port, then pulses done back to the register so it clears its start bit.
- Sits between the control register and the PE array, operand buffers and result buffer.

Parameters:
- DIM_W, 2, width of each dimension field; encoded value v means size v+1.
- CNT_W, 4, width of the compute-cycle counter; must hold 3*(2^DIM_W)-2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- control_register_i  in  16  bit0 start, bit1 mode, [7:6] dataflow, [9:8] n, [11:10] k, [13:12] m, bit14 reload A, bit15 reload B.
- op_req_o  out  1  operand fetch request.
- op_sel_o  out  1  0 = A (n x k), 1 = B (k x m).
- op_row_o  out  DIM_W  operand row index.
- op_col_o  out  DIM_W  operand column index.
- op_gnt_i  in  1  operand fetch accepted this cycle.
- pe_clear_o  out  1  one-cycle accumulator clear.
- pe_en_o  out  1  PE array step enable.
- res_valid_o  out  1  result element valid.
- res_row_o  out  DIM_W  result row index.
- res_col_o  out  DIM_W  result column index.
- res_ready_i  in  1  result sink ready.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse to the control register.
- error_o  out  1  sticky reserved-dataflow error.
- state_o  out  3  current state encoding.

Behaviour:
- Reset (async, any state): state = IDLE; all counters 0; all outputs 0; latched fields 0; error_o = 0.
- States and encodings: IDLE=0, CLEAR=1, LOAD_A=2, LOAD_B=3, COMPUTE=4, WRITEBACK=5, DONE=6.
- IDLE: start is accepted only when bit0=1 and bit1 (mode)=0.
  - On accept, latch fields n, k, m, reload A, reload B and dataflow.
  - Dataflow==3 is reserved: set error_o, stay in IDLE, pulse done_o for one cycle so start clears.
  - error_o clears only on the next accepted valid start.
- CLEAR: pe_clear_o=1 for exactly 1 cycle, then go to LOAD_A.
  - If reload A=0, skip to LOAD_B; if reload B is also 0, skip to COMPUTE.
- LOAD_A: op_req_o=1, op_sel_o=0, row-major scan (row 0..n, col 0..k).
  - Indices advance only on a cycle with op_req_o && op_gnt_i.
  - After the last element (row==n, col==k granted), go to LOAD_B if reload B=1, else COMPUTE.
  - Request and indices are held stable until granted.
- LOAD_B: same scan over k x m with op_sel_o=1; last grant goes to COMPUTE.
- COMPUTE: pe_en_o=1 for exactly (n+1)+(k+1)+(m+1)-2 consecutive cycles, then go to WRITEBACK.
  - Counter counts 0..limit-1 and is zero on entry.
- WRITEBACK: res_valid_o=1, row-major scan of (n+1) x (m+1).
  - Advance on res_valid_o && res_ready_i; valid and indices are held while ready is low.
  - Last accepted element goes to DONE.
- DONE: done_o=1 for 1 cycle, then return to IDLE.
  - Start is not re-sampled in this state.
  - Start is re-sampled in IDLE from the next cycle; the register has cleared bit0 by then.
- Changes to control_register_i while busy are ignored; only latched fields are used.
- Degenerate sizes: 1x1x1 gives 1 fetch each, 1 compute cycle, 1 result.
  - Max size 4x4x4 gives 16 fetches each, 10 compute cycles, 16 results.
- Minimum total latency with no stalls, start accept to done_o: 1 (CLEAR) + fetches + compute + results + 1 cycles.
- Reset mid-operation: immediate return to IDLE; no done_o is produced.

Test Plan:
1. Reset, then ctrl=16'hC001 (n=k=m=0, reload both), op_gnt_i=1, res_ready_i=1 -> CLEAR 1 cycle, 1 A fetch, 1 B fetch, pe_en_o 1 cycle, 1 result (0,0), done_o pulse; busy_o high 6 cycles.
2. ctrl=16'hFF01 (4x4x4), grant and ready always high -> 16 A fetches, 16 B fetches, pe_en_o 10 cycles, 16 results with last index (3,3), done_o once.
3. 2x2x2, reload A=1, reload B=0, op_gnt_i toggling every other cycle -> 4 A fetches only, indices held during non-grant cycles, no op_sel_o=1 cycles.
4. res_ready_i low for 3 cycles mid-WRITEBACK -> res_valid_o stays high, indices frozen, no element skipped or repeated.
5. ctrl dataflow=3 with start=1 -> error_o=1, done_o 1-cycle pulse, no fetch, no pe_en_o; a following valid start clears error_o.
6. Assert rst_i during COMPUTE -> all outputs 0 at once, state_o=0, no done_o; a fresh start then completes normally.
